// File: rtl/ser64_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : ser64_pkg                                                  |
// | Purpose  : Shared constants for the 64-bit serial register loader:    |
// |            FSM state encodings, default geometry, index widths.       |
// | Ports    : none (package)                                             |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
package ser64_pkg;

  // Default register file geometry: 16 registers of 4 bits = 64-bit frame
  localparam int NREG_DEF = 16;
  localparam int NBIT_DEF = 4;

  // Index widths for the default geometry
  localparam int RW = $clog2(NREG_DEF);
  localparam int BW = $clog2(NBIT_DEF);

  // Loader FSM state encodings
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RECV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

endpackage : ser64_pkg
`default_nettype wire

// File: rtl/ser64_loader_rf16x4.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : rf16x4                                                     |
// | Purpose  : NREG x NBIT register file, one synchronous write port and  |
// |            one combinational read port, asynchronous clear.           |
// | Ports    : tick_i     clock, rising edge                              |
// |            clr_i      asynchronous active-high clear (all entries 0)  |
// |            we_i       write enable                                    |
// |            wa_i       write address                                   |
// |            wd_i       write data                                      |
// |            rd_addr_i  read address                                    |
// |            rd_data_o  combinational read data (old value on a         |
// |                       same-cycle write, no bypass)                    |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
module rf16x4
  import ser64_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int NBIT = NBIT_DEF
) (
  input  logic                    tick_i,
  input  logic                    clr_i,
  input  logic                    we_i,
  input  logic [$clog2(NREG)-1:0] wa_i,
  input  logic [NBIT-1:0]         wd_i,
  input  logic [$clog2(NREG)-1:0] rd_addr_i,
  output logic [NBIT-1:0]         rd_data_o
);

  logic [NBIT-1:0] mem_q [NREG];

  always_ff @(posedge tick_i or posedge clr_i) begin
    if (clr_i) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[wa_i] <= wd_i;
    end
  end

  // Read reflects the stored array only, so a colliding write shows up
  // one cycle later.
  assign rd_data_o = mem_q[rd_addr_i];

endmodule : rf16x4
`default_nettype wire

// File: rtl/ser64_loader.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : ser64_loader                                               |
// | Purpose  : Receives a 64-bit serial frame (bit index fastest, then    |
// |            register index) and deposits it into a 16 x 4 register     |
// |            file. Stream bit k lands in reg[k/NBIT] bit k%NBIT.        |
// | Ports    : tick_i        clock, rising edge                           |
// |            clr_i         asynchronous active-high reset               |
// |            start_i       one-cycle pulse, begins/restarts a frame     |
// |            sdi_i         serial data bit                              |
// |            sdi_vld_i     qualifier, one bit consumed per high cycle   |
// |            rd_addr_i     read port register index                     |
// |            rd_data_o     combinational read of reg[rd_addr_i]         |
// |            rg_a_o        register index of the next bit               |
// |            bit_a_o       bit index of the next bit                    |
// |            busy_o        high while receiving                         |
// |            frame_done_o  one-cycle pulse after the last bit           |
// |            ovr_o         sticky error: bit offered outside a frame    |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
module ser64_loader
  import ser64_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int NBIT = NBIT_DEF
) (
  input  logic                    tick_i,
  input  logic                    clr_i,
  input  logic                    start_i,
  input  logic                    sdi_i,
  input  logic                    sdi_vld_i,
  input  logic [$clog2(NREG)-1:0] rd_addr_i,
  output logic [NBIT-1:0]         rd_data_o,
  output logic [$clog2(NREG)-1:0] rg_a_o,
  output logic [$clog2(NBIT)-1:0] bit_a_o,
  output logic                    busy_o,
  output logic                    frame_done_o,
  output logic                    ovr_o
);

  localparam int RWL = $clog2(NREG);
  localparam int BWL = $clog2(NBIT);
  localparam int CW  = RWL + BWL;

  localparam logic [CW-1:0]  CNT_LAST = {CW{1'b1}};
  localparam logic [BWL-1:0] BIT_LAST = {BWL{1'b1}};

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;     // {register index, bit index}
  logic [NBIT-1:0] asm_q, asm_d;     // nibble under assembly
  logic            ovr_q, ovr_d;

  logic [NBIT-1:0] nib_w;            // assembly nibble with current sdi merged
  logic            take_w;           // a stream bit is consumed this cycle
  logic            we_w;             // completed nibble written this cycle
  logic            ovr_set_w;

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge tick_i or posedge clr_i) begin
    if (clr_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_RECV;
      end
      S_RECV: begin
        // A restart keeps us in RECV and takes precedence over the last bit
        if (!start_i && sdi_vld_i && (cnt_q == CNT_LAST)) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = start_i ? S_RECV : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  always_comb begin
    busy_o       = (state_q == S_RECV);
    frame_done_o = (state_q == S_DONE);
    take_w       = busy_o && sdi_vld_i && !start_i;
    we_w         = take_w && (cnt_q[BWL-1:0] == BIT_LAST);
  end

  // ---------------------------------------------------------------------
  // Counter, assembly nibble and overrun flag
  // ---------------------------------------------------------------------
  assign ovr_set_w = sdi_vld_i && (state_q != S_RECV);

  always_comb begin
    nib_w                 = asm_q;
    nib_w[cnt_q[BWL-1:0]] = sdi_i;
    cnt_d                 = cnt_q;
    asm_d                 = asm_q;
    if (start_i) begin
      // Restart discards the partial nibble; the current sdi is ignored
      cnt_d = '0;
      asm_d = '0;
    end else if (take_w) begin
      // Single combined counter: wraps to 0 after the last bit
      cnt_d = cnt_q + CW'(1);
      asm_d = we_w ? '0 : nib_w;
    end
    ovr_d = start_i ? 1'b0 : (ovr_q | ovr_set_w);
  end

  always_ff @(posedge tick_i or posedge clr_i) begin
    if (clr_i) begin
      cnt_q <= '0;
      asm_q <= '0;
      ovr_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      asm_q <= asm_d;
      ovr_q <= ovr_d;
    end
  end

  assign rg_a_o  = cnt_q[CW-1:BWL];
  assign bit_a_o = cnt_q[BWL-1:0];
  assign ovr_o   = ovr_q;

  // ---------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------
  rf16x4 #(
    .NREG (NREG),
    .NBIT (NBIT)
  ) u_rf (
    .tick_i    (tick_i),
    .clr_i     (clr_i),
    .we_i      (we_w),
    .wa_i      (rg_a_o),
    .wd_i      (nib_w),
    .rd_addr_i (rd_addr_i),
    .rd_data_o (rd_data_o)
  );

endmodule : ser64_loader
`default_nettype wire
